// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types, defaults and width helper for the display scanner
package scan_pkg;

    typedef enum logic {
        S_ACTIVE = 1'b0,
        S_BLANK  = 1'b1
    } scan_state_t;

    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_DIV_CYCLES   = 10000;
    localparam int DEF_BLANK_CYCLES = 16;

    // Width able to index n distinct values; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - scan enable and channel drive bundle for the display scanner
//
// Signals:
//   en       scan enable, driven by the controller side
//   ch_sel   index of the channel currently presented (steers the data mux)
//   ch_en_n  active-low one-hot channel drive
//   blank    high while every channel is dark during dead-time
//   tick     one-cycle pulse when a new ch_sel value is first presented
// Modports: master = scanner (drives channel outputs), slave = consumer (drives en).
interface display_scanner_if #(
    parameter int NUM_CH = scan_pkg::DEF_NUM_CH
);
    localparam int SEL_W = scan_pkg::sel_width(NUM_CH);

    logic             en;
    logic [SEL_W-1:0] ch_sel;
    logic [NUM_CH-1:0] ch_en_n;
    logic             blank;
    logic             tick;

    modport master (
        input  en,
        output ch_sel,
        output ch_en_n,
        output blank,
        output tick
    );

    modport slave (
        output en,
        input  ch_sel,
        input  ch_en_n,
        input  blank,
        input  tick
    );

endinterface

// File: rtl/display_scanner_tick_gen.sv
// rtl/display_scanner_tick_gen.sv - enabled modulo-TC counter with terminal-count strobe
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-low; clears the count
//   en     count enable; the count holds while low
//   done   high in the enabled cycle whose count is TC-1 (the count clears on that edge)
module tick_gen
    import scan_pkg::*;
#(
    parameter int TC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic done
);

    localparam int W = sel_width(TC);

    logic [W-1:0] count;

    assign done = en && (count == W'(TC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (done) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed display channel scanner with optional dead-time
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-low
//   bus    display_scanner_if.master: en in; ch_sel, ch_en_n, blank, tick out (all registered)
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES of dead-time between channels;
// without it the channel advances directly at the end of each dwell and blank stays 0.
module display_scanner
    import scan_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DIV_CYCLES   = DEF_DIV_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.master bus
);

    localparam int SEL_W = sel_width(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("display_scanner: NUM_CH must be in 2..16");
    end
    if (DIV_CYCLES < 2) begin : g_bad_div
        $error("display_scanner: DIV_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > DIV_CYCLES - 1) begin : g_bad_blank
        $error("display_scanner: BLANK_CYCLES must be in 1..DIV_CYCLES-1");
    end

    scan_state_t       state;
    scan_state_t       state_next;
    logic [SEL_W-1:0]  ch_sel_inc;
    logic [SEL_W-1:0]  ch_sel_next;
    logic [NUM_CH-1:0] ch_en_n_next;
    logic              tick_next;
    logic              dwell_done;
    logic              blank_done;

    // Wrap explicitly so ch_sel never reaches NUM_CH even when NUM_CH is not a power of two.
    assign ch_sel_inc = (bus.ch_sel == SEL_W'(NUM_CH - 1)) ? '0 : bus.ch_sel + 1'b1;

    tick_gen #(.TC(DIV_CYCLES)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en && (state == S_ACTIVE)),
        .done  (dwell_done)
    );

`ifdef SCAN_BLANK_EN
    logic blank_next;

    tick_gen #(.TC(BLANK_CYCLES)) u_blank (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en && (state == S_BLANK)),
        .done  (blank_done)
    );
`else
    assign blank_done = 1'b0;
    assign bus.blank  = 1'b0;
`endif

    // done strobes already include en, so a disabled cycle keeps everything and tick low.
    always_comb begin
        state_next   = state;
        ch_sel_next  = bus.ch_sel;
        ch_en_n_next = bus.ch_en_n;
        tick_next    = 1'b0;
`ifdef SCAN_BLANK_EN
        blank_next   = bus.blank;
`endif
        case (state)
            S_ACTIVE: begin
                if (dwell_done) begin
`ifdef SCAN_BLANK_EN
                    state_next   = S_BLANK;
                    ch_en_n_next = '1;
                    blank_next   = 1'b1;
`else
                    ch_sel_next  = ch_sel_inc;
                    ch_en_n_next = ~(NUM_CH'(1) << ch_sel_inc);
                    tick_next    = 1'b1;
`endif
                end
            end
            S_BLANK: begin
                if (blank_done) begin
                    state_next   = S_ACTIVE;
                    ch_sel_next  = ch_sel_inc;
                    ch_en_n_next = ~(NUM_CH'(1) << ch_sel_inc);
                    tick_next    = 1'b1;
`ifdef SCAN_BLANK_EN
                    blank_next   = 1'b0;
`endif
                end
            end
            default: begin
                state_next = S_ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_ACTIVE;
            bus.ch_sel  <= '0;
            bus.ch_en_n <= ~NUM_CH'(1);
            bus.tick    <= 1'b0;
`ifdef SCAN_BLANK_EN
            bus.blank   <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            bus.ch_sel  <= ch_sel_next;
            bus.ch_en_n <= ch_en_n_next;
            bus.tick    <= tick_next;
`ifdef SCAN_BLANK_EN
            bus.blank   <= blank_next;
`endif
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized scoreboard bench for display_scanner (two configurations)
module tb_display_scanner;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] en_n;
        logic        blank;
        logic        tick;
    } exp_t;

`ifdef SCAN_BLANK_EN
    localparam int BLK_A = 2;
    localparam int BLK_B = 1;
`else
    localparam int BLK_A = 0;
    localparam int BLK_B = 0;
`endif
    localparam int NCH_A = 3, DIV_A = 4;
    localparam int NCH_B = 5, DIV_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    always #5 clk = ~clk;

    display_scanner_if #(.NUM_CH(NCH_A)) bus_a ();
    display_scanner_if #(.NUM_CH(NCH_B)) bus_b ();
    assign bus_a.en = en;
    assign bus_b.en = en;

    display_scanner #(.NUM_CH(NCH_A), .DIV_CYCLES(DIV_A), .BLANK_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    display_scanner #(.NUM_CH(NCH_B), .DIV_CYCLES(DIV_B), .BLANK_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int   vectors = 0;
    int   miscompares = 0;
    bit   armed = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur_a;
    int   n = 0;          // enabled edges since the last reset
    bit   ten = 0;        // whether the most recent edge was enabled
    int   exp_ticks_b = 0;
    int   dut_ticks_b = 0;

    // Reference: the scan is a pure function of how many enabled edges have passed.
    function automatic exp_t model(input int cnt, input bit last_en, input int nch, input int div,
                                   input int blk);
        exp_t m;
        int   p;
        int   pos;
        int   ch;
        p      = div + blk;
        pos    = cnt % p;
        ch     = (cnt / p) % nch;
        m.sel  = 4'(ch);
        m.blank = (pos >= div);
        m.en_n = 16'((1 << nch) - 1);
        if (!m.blank) m.en_n[ch] = 1'b0;
        m.tick = last_en && (cnt > 0) && (pos == 0);
        return m;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got sel=%0d en_n=%h blank=%b tick=%b want sel=%0d en_n=%h blank=%b tick=%b",
                     name, $time, got.sel, got.en_n, got.blank, got.tick,
                     exp.sel, exp.en_n, exp.blank, exp.tick);
        end
    endtask

    task automatic step(input bit r, input bit e);
        exp_t eb;
        @(negedge clk);
        reset = r;
        en    = e;
        armed = 1;
        @(posedge clk);
        if (!r) begin
            n   = 0;
            ten = 0;
        end else if (e) begin
            n++;
            ten = 1;
        end else begin
            ten = 0;
        end
        cur_a = model(n, ten, NCH_A, DIV_A, BLK_A);
        eb    = model(n, ten, NCH_B, DIV_B, BLK_B);
        q_a.push_back(cur_a);
        q_b.push_back(eb);
        if (eb.tick) exp_ticks_b++;
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s target state not reached within cycle budget", name);
    endtask

    // Monitor: every cycle the scanners present outputs; pop the matching expectation.
    initial begin
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (q_a.size() == 0) begin
                    bound_fail("queue_a_empty");
                end else begin
                    got = '{sel: 4'(bus_a.ch_sel), en_n: 16'(bus_a.ch_en_n),
                            blank: bus_a.blank, tick: bus_a.tick};
                    check("scan_a", got, q_a.pop_front());
                end
                if (q_b.size() == 0) begin
                    bound_fail("queue_b_empty");
                end else begin
                    got = '{sel: 4'(bus_b.ch_sel), en_n: 16'(bus_b.ch_en_n),
                            blank: bus_b.blank, tick: bus_b.tick};
                    check("scan_b", got, q_b.pop_front());
                    if (bus_b.tick === 1'b1) dut_ticks_b++;
                end
            end
        end
    end

    initial begin
        int i;
        // Reset with en high: reset must win.
        repeat (3) step(0, 1);
        dut_ticks_b = 0;
        exp_ticks_b = 0;
        // Three full frames of A with continuous enable; B runs alongside.
        repeat (NCH_A * (DIV_A + BLK_A) * 3) step(1, 1);

        // Randomized enable with occasional resets.
        repeat (600) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0));
        end

        // Reset landing on channel 2 while dark (or simply on channel 2 without dead-time).
        step(0, 1);
        for (i = 0; i < 200; i++) begin
            if (cur_a.sel == 2 && (cur_a.blank || BLK_A == 0)) break;
            step(1, 1);
        end
        if (i == 200) bound_fail("reach_ch2");
        step(0, 1);
        step(1, 1);

        // Freeze for 5 cycles at blank count 1 (or mid-dwell without dead-time).
        step(0, 1);
        for (i = 0; i < 200; i++) begin
            if ((n % (DIV_A + BLK_A)) == ((BLK_A > 0) ? DIV_A + 1 : 2)) break;
            step(1, 1);
        end
        if (i == 200) bound_fail("reach_hold_point");
        repeat (5) step(1, 0);
        repeat (20) step(1, 1);

        // Enable toggling right at terminal counts.
        repeat (100) step(1, 1'($urandom_range(0, 1)));

        @(negedge clk);
        armed = 0;
        vectors++;
        if (dut_ticks_b != exp_ticks_b) begin
            miscompares++;
            $display("FAIL tick_count_b got %0d want %0d", dut_ticks_b, exp_ticks_b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
